// File: rtl/vote_logger.sv
// Four-candidate vote counter: per-button debounce with one-shot arming,
// a lockout/release FSM, and saturating 8-bit totals.
module vote_logger #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic [7:0] candidate1_vote,
    output logic [7:0] candidate2_vote,
    output logic [7:0] candidate3_vote,
    output logic [7:0] candidate4_vote,
    output logic       valid_vote_casted
);

    typedef enum logic [1:0] {
        IDLE,
        LOCKOUT,
        WAIT_RELEASE
    } state_t;

    localparam logic [7:0] DEB_MAX   = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] DEB_PRE   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

    logic [3:0] buttons;
    logic [7:0] deb_cnt [4];
    logic [3:0] armed;
    logic [3:0] qual;

    state_t     state;
    logic [7:0] lock_cnt;
    logic [7:0] votes [4];

    logic       multi;
    logic [1:0] sel;

    assign buttons = {button4, button3, button2, button1};

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= 8'd0;
            end
            armed <= 4'b1111;
            qual  <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!buttons[i]) begin
                    deb_cnt[i] <= 8'd0;
                    armed[i]   <= 1'b1;
                    qual[i]    <= 1'b0;
                end else begin
                    if (deb_cnt[i] != DEB_MAX) begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                    // Qualify on the edge the counter reaches the window; one shot per hold.
                    qual[i] <= armed[i] && (deb_cnt[i] == DEB_PRE);
                    if (armed[i] && (deb_cnt[i] == DEB_PRE)) begin
                        armed[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign multi = |(qual & (qual - 4'd1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (qual[i]) begin
                sel = 2'(i);
            end
        end
    end

    // NOTE: the vote registers are real state that must read zero after reset,
    // so they are reset here rather than left as an unreset memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            lock_cnt          <= 8'd0;
            valid_vote_casted <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                votes[i] <= 8'd0;
            end
        end else begin
            valid_vote_casted <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mode && (qual != 4'b0000)) begin
                        if (multi || (votes[sel] == 8'hFF)) begin
                            state <= WAIT_RELEASE;
                        end else begin
                            votes[sel]        <= votes[sel] + 8'd1;
                            valid_vote_casted <= 1'b1;
                            lock_cnt          <= LOCK_LOAD;
                            state             <= LOCKOUT;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt <= 8'd1) begin
                        lock_cnt <= 8'd0;
                        state    <= WAIT_RELEASE;
                    end else begin
                        lock_cnt <= lock_cnt - 8'd1;
                    end
                end
                WAIT_RELEASE: begin
                    if (buttons == 4'b0000) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign candidate1_vote = votes[0];
    assign candidate2_vote = votes[1];
    assign candidate3_vote = votes[2];
    assign candidate4_vote = votes[3];

endmodule

// File: tb/tb_vote_logger.sv
// Scoreboard bench for vote_logger: expected vote totals are queued when a
// press is driven and compared whenever the DUT raises valid_vote_casted.
module tb_vote_logger;

    localparam int D = 4;
    localparam int L = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       button1, button2, button3, button4;
    logic [7:0] c1, c2, c3, c4;
    logic       valid;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  model [4];
    logic [31:0] dut_word;

    always #5 clk = ~clk;

    vote_logger #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .button1          (button1),
        .button2          (button2),
        .button3          (button3),
        .button4          (button4),
        .candidate1_vote  (c1),
        .candidate2_vote  (c2),
        .candidate3_vote  (c3),
        .candidate4_vote  (c4),
        .valid_vote_casted(valid)
    );

    assign dut_word = {c4, c3, c2, c1};

    function automatic logic [31:0] model_word();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Each pulse pops one expected set of totals.
    always @(negedge clk) begin
        if (!reset && valid === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse counts=%h at %0t", dut_word, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dut_word !== e) begin
                    failures++;
                    $display("FAIL pulse_counts got=%h expected=%h at %0t", dut_word, e, $time);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_button(input int b, input logic v);
        case (b)
            1: button1 = v;
            2: button2 = v;
            3: button3 = v;
            default: button4 = v;
        endcase
    endtask

    task automatic hold(input int b, input int n);
        @(negedge clk);
        set_button(b, 1'b1);
        repeat (n) @(posedge clk);
        @(negedge clk);
        set_button(b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_vote(input int b);
        model[b-1] = model[b-1] + 8'd1;
        exp_q.push_back(model_word());
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0;
        button1 = 1'b0; button2 = 1'b0; button3 = 1'b0; button4 = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 8'd0;
        #12;
        checks++;
        if (dut_word !== 32'h0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state counts=%h valid=%b expected 0/0", dut_word, valid);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        checks++;
        if (dut_word !== 32'h0 || pulses != 0) begin
            failures++;
            $display("FAIL post_reset_idle counts=%h pulses=%0d expected 0/0", dut_word, pulses);
        end
    endtask

    task automatic test_single();
        expect_vote(2);
        @(negedge clk);
        button2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid !== 1'(k == 5)) begin
                failures++;
                $display("FAIL latency edge=%0d valid=%b expected=%b", k, valid, (k == 5));
            end
        end
        button2 = 1'b0;
        idle(14);
        checks++;
        if (dut_word !== model_word() || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_vote counts=%h expected=%h pending=%0d", dut_word, model_word(), exp_q.size());
        end
    endtask

    task automatic test_long_hold();
        int p0;
        p0 = pulses;
        expect_vote(1);
        expect_vote(1);
        hold(1, 50);
        hold(1, 6);
        idle(14);
        checks++;
        if (c1 !== 8'd2 || pulses != p0 + 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL long_hold c1=%0d pulses=%0d expected c1=2 pulses=%0d", c1, pulses - p0, 2);
        end
    endtask

    task automatic test_lockout();
        int p0;
        p0 = pulses;
        expect_vote(4);
        hold(4, 6);
        hold(3, 20);
        checks++;
        if (pulses != p0 + 1 || dut_word !== model_word()) begin
            failures++;
            $display("FAIL lockout_discard pulses=%0d expected=1 counts=%h", pulses - p0, dut_word);
        end
        idle(3);
        expect_vote(3);
        hold(3, 6);
        idle(14);
        checks++;
        if (dut_word !== model_word() || pulses != p0 + 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL lockout_repress counts=%h expected=%h", dut_word, model_word());
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        p0 = pulses;
        @(negedge clk);
        button1 = 1'b1;
        button4 = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        button1 = 1'b0;
        hold(2, 6);
        idle(3);
        checks++;
        if (pulses != p0 || dut_word !== model_word()) begin
            failures++;
            $display("FAIL simultaneous pulses=%0d expected=0 counts=%h expected=%h", pulses - p0, dut_word, model_word());
        end
        @(negedge clk);
        button4 = 1'b0;
        idle(3);
        expect_vote(2);
        hold(2, 6);
        idle(14);
        checks++;
        if (dut_word !== model_word() || pulses != p0 + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_release counts=%h expected=%h", dut_word, model_word());
        end
    endtask

    task automatic test_mode();
        int p0;
        p0 = pulses;
        @(negedge clk);
        mode = 1'b1;
        hold(1, 6);
        idle(3);
        checks++;
        if (pulses != p0 || dut_word !== model_word()) begin
            failures++;
            $display("FAIL result_mode pulses=%0d expected=0 counts=%h", pulses - p0, dut_word);
        end
        @(negedge clk);
        button3 = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        mode = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        button3 = 1'b0;
        idle(3);
        checks++;
        if (pulses != p0 || dut_word !== model_word()) begin
            failures++;
            $display("FAIL mode_switch_hold pulses=%0d expected=0 counts=%h", pulses - p0, dut_word);
        end
        expect_vote(3);
        hold(3, 6);
        idle(14);
        checks++;
        if (dut_word !== model_word() || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mode_back_to_vote counts=%h expected=%h", dut_word, model_word());
        end
    endtask

    task automatic test_reset_mid_lockout();
        expect_vote(2);
        @(negedge clk);
        button2 = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_word !== 32'h0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset counts=%h valid=%b expected 0/0", dut_word, valid);
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) model[i] = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        expect_vote(2);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid !== 1'(k == 5)) begin
                failures++;
                $display("FAIL post_reset_window edge=%0d valid=%b expected=%b", k, valid, (k == 5));
            end
        end
        button2 = 1'b0;
        idle(14);
        checks++;
        if (dut_word !== model_word() || exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_count counts=%h expected=%h", dut_word, model_word());
        end
    endtask

    task automatic test_saturation();
        int p0;
        while (model[1] < 8'd255) begin
            expect_vote(2);
            hold(2, 6);
            idle(13);
        end
        checks++;
        if (c2 !== 8'd255 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fill_to_255 c2=%0d expected=255", c2);
        end
        p0 = pulses;
        hold(2, 6);
        idle(13);
        checks++;
        if (c2 !== 8'd255 || pulses != p0 || dut_word !== model_word()) begin
            failures++;
            $display("FAIL saturation c2=%0d pulses=%0d expected c2=255 pulses=0", c2, pulses - p0);
        end
        expect_vote(1);
        hold(1, 6);
        idle(14);
        checks++;
        if (dut_word !== model_word() || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_saturation counts=%h expected=%h", dut_word, model_word());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_long_hold();
        test_lockout();
        test_simultaneous();
        test_mode();
        test_reset_mid_lockout();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
